// File: rtl/mips_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step.
// Purely combinational; {acc_hi, acc_lo} is product/multiplier or remainder/dividend-quotient.
module mdu_step
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum     = {1'b0, acc_hi} + ({1'b0, m} & {(WIDTH+1){acc_lo[0]}});
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, m});
    // Only consumed when shifted >= m, so the modulo-2^WIDTH difference is exact.
    diff    = shifted[WIDTH-1:0] - m;
    if (is_div) begin
      nxt_hi = ge ? diff : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO; signed ops need MDU_SIGNED_EN.
// Latency: done in cycle WIDTH+1 after start (cycle 1 for divide-by-zero); ready again one cycle later.
// Backpressure: ready=0/busy=1 while an op is in flight; start and HI/LO writes are dropped then.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, m_r;
  logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo, mag_a, mag_b;
  logic             is_div_r, dz_r, start_ok, in_div, in_dz, fin_we;

  assign in_div   = (op == MDU_DIV) || (op == MDU_DIVU);
  assign in_dz    = in_div && (b == '0);
  assign start_ok = (state == IDLE) && start && !abort;

`ifdef MDU_SIGNED_EN
  logic                 in_sgn, neg_a, neg_b, neg_a_r, neg_b_r;
  logic [2*WIDTH-1:0]   prod;

  assign in_sgn = (op == MDU_MULT) || (op == MDU_DIV);
  assign neg_a  = in_sgn && a[WIDTH-1];
  assign neg_b  = in_sgn && b[WIDTH-1];
  assign mag_a  = neg_a ? -a : a;
  assign mag_b  = neg_b ? -b : b;

  // Divide-by-zero returns the raw dividend, so its sign flags stay clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_a_r <= 1'b0;
      neg_b_r <= 1'b0;
    end else if (start_ok) begin
      neg_a_r <= neg_a && !in_dz;
      neg_b_r <= neg_b && !in_dz;
    end
  end

  always_comb begin
    prod   = {acc_hi, acc_lo};
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (is_div_r) begin
      if (neg_a_r ^ neg_b_r) res_lo = -acc_lo;
      if (neg_a_r)           res_hi = -acc_hi;
    end else if (neg_a_r ^ neg_b_r) begin
      prod            = -prod;
      {res_hi, res_lo} = prod;
    end
  end
`else
  assign mag_a  = a;
  assign mag_b  = b;
  assign res_hi = acc_hi;
  assign res_lo = acc_lo;
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_r),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .m      (m_r),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fin_we      = 1'b0;
    busy        = (state != IDLE);
    ready       = (state == IDLE);
    case (state)
      IDLE: if (start_ok) state_nxt = in_dz ? FIN : RUN;
      RUN: begin
        if (abort)                        state_nxt = IDLE;
        else if (cnt == CW'(WIDTH - 1))   state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
        fin_we    = !abort;
      end
      default: state_nxt = IDLE;
    endcase
    done        = fin_we;
    div_by_zero = fin_we && dz_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      m_r      <= '0;
      is_div_r <= 1'b0;
      dz_r     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (start_ok) begin
        cnt      <= '0;
        is_div_r <= in_div;
        dz_r     <= in_dz;
        if (in_dz) begin
          acc_hi <= a;
          acc_lo <= '1;
        end else if (in_div) begin
          acc_hi <= '0;
          acc_lo <= mag_a;
          m_r    <= mag_b;
        end else begin
          acc_hi <= '0;
          acc_lo <= mag_b;
          m_r    <= mag_a;
        end
      end else if (state == RUN) begin
        cnt    <= cnt + CW'(1);
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end
      // MTHI/MTLO only land in a quiet IDLE cycle; a same-cycle start wins.
      if (fin_we) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int W = MDU_WIDTH;

  logic          clk = 1'b0;
  logic          rst, start, abort, hi_we, lo_we;
  mdu_op_t       op;
  logic [W-1:0]  a, b, wdata, hi, lo;
  logic          ready, busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .abort       (abort),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
    logic        sgn;
    longint      sx, sy, q, rm;
    logic [63:0] r, qv, rv;
`ifdef MDU_SIGNED_EN
    sgn = (o == MDU_MULT) || (o == MDU_DIV);
`else
    sgn = 1'b0;
`endif
    sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
    sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
    if (o == MDU_MULT || o == MDU_MULTU) begin
      r = 64'(sx * sy);
    end else if (y == 32'd0) begin
      r = {x, 32'hFFFF_FFFF};
    end else begin
      q  = sx / sy;
      rm = sx % sy;
      qv = 64'(q);
      rv = 64'(rm);
      r  = {rv[31:0], qv[31:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one op; optionally pokes a stray start mid-flight, which must be ignored.
  task automatic run_op(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke, output int lat, output logic dz);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    dz  = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (poke && c == 3) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        op    = mdu_op_t'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = c;
        dz  = div_by_zero;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic        dz, seen;
    logic [31:0] x, y, h0, l0;
    logic [63:0] exp;
    mdu_op_t     o;
    bit          is_div;

    rst = 1'b1; start = 1'b0; abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = MDU_MULTU; a = '0; b = '0; wdata = '0;
    #12;
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", {done, div_by_zero}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full-scale unsigned multiply
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, dz);
    check("multu_lat", lat, 33);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check("multu_ready", ready, 1);

    // Signed divide -7 / 2
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, dz);
    check("div_lat", lat, 33);
`ifdef MDU_SIGNED_EN
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    check("div_hilo", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
`endif

    // Divide by zero
    run_op(MDU_DIVU, 32'd100, 32'd0, 0, lat, dz);
    check("dz_lat", lat, 1);
    check("dz_flag", dz, 1);
    check("dz_hilo", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

    // Overflow divide
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, dz);
    check("ovf_hilo", {hi, lo}, model(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF));
    check("ovf_dz", dz, 0);

    // MTHI / MTLO in IDLE
    @(negedge clk); hi_we = 1'b1; wdata = 32'hAAAA_0001;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555_0002;
    @(negedge clk); lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'hAAAA_0001_5555_0002);

    // Abort mid-RUN
    @(negedge clk); op = MDU_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done) seen = 1'b1;
      if (c == 20) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort_nodone", seen, 0);
    check("abort_ready", ready, 1);
    check("abort_hilo", {hi, lo}, 64'hAAAA_0001_5555_0002);
    run_op(MDU_MULT, 32'd3, 32'd5, 0, lat, dz);
    check("post_abort_lat", lat, 33);
    check("post_abort_hilo", {hi, lo}, 64'd15);

    // Abort while in FIN
    h0 = hi; l0 = lo;
    @(negedge clk); op = MDU_MULTU; a = 32'd7; b = 32'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (busy && !ready && c == 33) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("fin_reached", seen, 1);
    abort = 1'b1;
    #1;
    check("fin_abort_done", done, 0);
    @(negedge clk); abort = 1'b0;
    check("fin_abort_hilo", {hi, lo}, {h0, l0});
    check("fin_abort_ready", ready, 1);

    // MTLO while busy is dropped
    h0 = hi; l0 = lo;
    @(negedge clk); op = MDU_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk); lo_we = 1'b0;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("busy_mtlo_drop", lo, l0);
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk); lo_we = 1'b0;
    check("idle_mtlo", lo, 32'h0000_1234);

    // start + hi_we together: op starts, hi untouched
    h0 = hi;
    op = MDU_MULTU; a = 32'd6; b = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'hBEEF;
    @(negedge clk); start = 1'b0; hi_we = 1'b0;
    check("start_wins_busy", busy, 1);
    check("start_wins_hi", hi, h0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("start_wins_hi2", hi, h0);

    // Asynchronous reset mid-RUN
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'h1234_5678, 0, lat, dz);
    @(negedge clk); op = MDU_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_hilo", {hi, lo}, 64'h0);
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      o      = mdu_op_t'($urandom_range(0, 3));
      x      = rnd_opnd();
      y      = rnd_opnd();
      is_div = (o == MDU_DIV) || (o == MDU_DIVU);
      exp    = model(o, x, y);
      run_op(o, x, y, bit'($urandom_range(0, 1)), lat, dz);
      check($sformatf("rnd%0d_lat", i), lat, (is_div && y == 0) ? 1 : 33);
      check($sformatf("rnd%0d_dz", i), dz, (is_div && y == 0) ? 1 : 0);
      check($sformatf("rnd%0d_hilo op=%0d a=%h b=%h", i, o, x, y), {hi, lo}, exp);
      check($sformatf("rnd%0d_ready", i), ready, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
